mmio_responder: RTL and testbench
=================================

Name: mmio_responder

Overview:
- Responder on the processor's data-memory port, alongside the dmem syncram.
- Decodes a small address window at the top of the 12-bit dmem space and answers loads and stores there from internal registers. These are an LED register, a free-running cycle counter, and a byte-wide transmit FIFO drained by a ready/valid sink.
- Stores to the window are suppressed from dmem. The top level selects q_mmio over q_dmem whenever mmio_hit is high.

Parameters:
- ADDR_WIDTH, 12, width of address_dmem.
- DATA_WIDTH, 32, width of store/load data.
- MMIO_BASE, 12'hFF0, base of the 16-word MMIO window; only address bits [ADDR_WIDTH-1:4] are compared.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16.

Ports:
- clock  input  1  single system clock (processor_clock domain); all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- address_dmem  input  ADDR_WIDTH  word address from processor.
- data  input  DATA_WIDTH  store data from processor.
- wren  input  1  store enable from processor.
- mem_wren  output  1  wren forwarded to dmem; 0 when address is in window.
- q_mmio  output  DATA_WIDTH  registered load data for window accesses.
- mmio_hit  output  1  registered; high the cycle after a window address was presented.
- led  output  8  LED register contents.
- tx_data  output  8  byte at FIFO head.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  sink accepts head byte when tx_valid&&tx_ready.

Behaviour:
- Reset (reset=0, asynchronous) clears the following, and reset release takes effect on the next rising edge:
  - all outputs to 0: q_mmio, mmio_hit, led, tx_data, tx_valid;
  - FIFO empty, counter 0, overflow flag 0.
- hit = (address_dmem[ADDR_WIDTH-1:4] == MMIO_BASE[ADDR_WIDTH-1:4]); offset = address_dmem[3:0].
- mem_wren = wren & ~hit, combinational.
- Load latency is 1 cycle, matching the syncram:
  - q_mmio and mmio_hit register the read of the offset presented this cycle.
  - When hit=0, q_mmio is held at 0.
- Register map (by offset):
  - 0x0 LED, RW: write loads data[7:0]; read returns {24'b0, led}.
  - 0x1 CYCLE, RW:
    - increments every cycle and wraps 0xFFFFFFFF -> 0;
    - a write sets it to 0 at that edge (write beats increment);
    - a read returns the pre-edge value.
  - 0x2 TXDATA, WO: a write pushes data[7:0]; a read returns 0.
  - 0x3 STATUS:
    - read fields: bit0 full, bit1 empty, bits[8:4] count, bit9 overflow (sticky), other bits 0;
    - a write with data[9]=1 clears overflow; other bits are ignored.
  - 0x4..0xF: reads return 0; writes are ignored.
- Every read returns state before that same edge's updates.
- FIFO (circular buffer, rd/wr pointers plus a count of width log2(FIFO_DEPTH)+1):
  - push = wren&hit&offset==2; pop = tx_valid&tx_ready.
  - Push when not full: byte stored.
  - Push when full with no pop: byte dropped and overflow set.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle when neither empty nor full: count unchanged.
  - Pop when empty: impossible, since tx_valid=0.
  - No bypass: a push into an empty FIFO raises tx_valid on the next cycle.
  - tx_data = mem[rd_ptr]; it is stable while tx_valid&~tx_ready.
- Overflow set and clear in the same cycle: set wins.
- Pointer wrap-around at FIFO_DEPTH-1 -> 0 without data loss.

Test Plan:
- Reset behaviour: hold reset=0 mid-operation with a FIFO holding 3 bytes and led=0x5A -> immediately tx_valid=0, led=0, mmio_hit=0; after release, STATUS read returns 0x002 (empty).
- LED and dmem gating: store 0x1234_56A5 to 0xFF0 -> led=0xA5 next cycle, mem_wren=0 during the store; store to 0x010 -> mem_wren=1, led unchanged; load 0xFF0 -> q_mmio=0x0000_00A5, mmio_hit=1 one cycle later.
- Cycle counter: store 0 to 0xFF1, then load 0xFF1 ten cycles later -> q_mmio=9. Counter forced to 0xFFFF_FFFF -> reads 0 next cycle.
- FIFO fill, overflow and clear: with tx_ready=0, push bytes 0x01..0x09 -> STATUS = full, count 8, overflow 1, tx_data=0x01. Raise tx_ready -> sink receives 0x01..0x08 in order, 0x09 absent. Store 0x200 to STATUS -> overflow bit reads 0.
- Simultaneous push and pop when full: with tx_ready=1, push 0x10 in the same cycle the FIFO is full -> count stays 8, overflow stays 0, 0x10 is emitted last after pointer wrap.
- Empty push latency: with an empty FIFO, push 0x77 -> tx_valid=0 that cycle and tx_valid=1 with tx_data=0x77 the next.

Source files
------------

// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped register block sitting beside the dmem syncram.
// It answers a 16-word window at the top of the data address space with an LED
// register, a free-running cycle counter and a byte-wide transmit FIFO, and it
// keeps stores aimed at that window away from dmem.
module mmio_responder #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 12'hFF0,
    parameter int                    FIFO_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_dmem,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] q_mmio,
    output logic                  mmio_hit,
    output logic [7:0]            led,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam int PtrW = $clog2(FIFO_DEPTH);
    localparam int CntW = PtrW + 1;

    // Window decode: only the upper address bits select the block, the low
    // nibble picks the register.
    logic       hit;
    logic [3:0] offset;

    assign hit      = (address_dmem[ADDR_WIDTH-1:4] == MMIO_BASE[ADDR_WIDTH-1:4]);
    assign offset   = address_dmem[3:0];
    assign mem_wren = wren & ~hit;

    // Register state and its next-state values.
    logic [7:0]            led_q,       led_d;
    logic [DATA_WIDTH-1:0] cycle_q,     cycle_d;
    logic [PtrW-1:0]       wrPtr_q,     wrPtr_d;
    logic [PtrW-1:0]       rdPtr_q,     rdPtr_d;
    logic [CntW-1:0]       fifoCount_q, fifoCount_d;
    logic                  overflow_q,  overflow_d;
    logic [DATA_WIDTH-1:0] qMmio_q,     qMmio_d;
    logic                  mmioHit_q,   mmioHit_d;
    logic [7:0]            fifoMem_q [FIFO_DEPTH];

    // Decoded write strobes for each register.
    logic wrLed;
    logic wrCycle;
    logic push;
    logic wrStatus;

    assign wrLed    = wren & hit & (offset == 4'h0);
    assign wrCycle  = wren & hit & (offset == 4'h1);
    assign push     = wren & hit & (offset == 4'h2);
    assign wrStatus = wren & hit & (offset == 4'h3);

    // FIFO flags. A push into a full FIFO still lands when the head is being
    // popped in the same cycle, because that pop frees the slot being written.
    logic full;
    logic empty;
    logic pop;
    logic accept;

    assign empty  = (fifoCount_q == '0);
    assign full   = (fifoCount_q == CntW'(FIFO_DEPTH));
    assign pop    = tx_valid & tx_ready;
    assign accept = push & (~full | pop);

    assign tx_valid = ~empty;
    assign tx_data  = fifoMem_q[rdPtr_q];
    assign led      = led_q;
    assign q_mmio   = qMmio_q;
    assign mmio_hit = mmioHit_q;

    // Only a few store-data bits carry meaning; the rest are deliberately dropped.
    logic unusedDataBits;
    assign unusedDataBits = ^{data[DATA_WIDTH-1:10], data[8]};

    // Read mux built from pre-edge state so a read never sees its own cycle's update.
    logic [DATA_WIDTH-1:0] readData;

    always_comb begin
        readData = '0;
        case (offset)
            4'h0: readData[7:0] = led_q;
            4'h1: readData      = cycle_q;
            4'h3: begin
                readData[0]   = full;
                readData[1]   = empty;
                readData[8:4] = 5'(fifoCount_q);
                readData[9]   = overflow_q;
            end
            default: readData = '0;
        endcase
    end

    // Next-state logic for registers, counter, FIFO bookkeeping and load data.
    always_comb begin
        led_d       = wrLed ? data[7:0] : led_q;
        cycle_d     = wrCycle ? '0 : cycle_q + DATA_WIDTH'(1);
        wrPtr_d     = accept ? wrPtr_q + PtrW'(1) : wrPtr_q;
        rdPtr_d     = pop ? rdPtr_q + PtrW'(1) : rdPtr_q;
        fifoCount_d = fifoCount_q;
        case ({accept, pop})
            2'b10:   fifoCount_d = fifoCount_q + CntW'(1);
            2'b01:   fifoCount_d = fifoCount_q - CntW'(1);
            default: fifoCount_d = fifoCount_q;
        endcase
        overflow_d = overflow_q;
        if (push & full & ~pop) begin
            overflow_d = 1'b1;
        end else if (wrStatus & data[9]) begin
            overflow_d = 1'b0;
        end
        qMmio_d   = hit ? readData : '0;
        mmioHit_d = hit;
    end

    // State registers, cleared asynchronously while reset is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_q       <= '0;
            cycle_q     <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
            overflow_q  <= 1'b0;
            qMmio_q     <= '0;
            mmioHit_q   <= 1'b0;
        end else begin
            led_q       <= led_d;
            cycle_q     <= cycle_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            fifoCount_q <= fifoCount_d;
            overflow_q  <= overflow_d;
            qMmio_q     <= qMmio_d;
            mmioHit_q   <= mmioHit_d;
        end
    end

    // FIFO storage; cleared on reset so the head byte reads 0 while empty after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem_q[i] <= '0;
            end
        end else if (accept) begin
            fifoMem_q[wrPtr_q] <= data[7:0];
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed vectors with hand-computed expectations for the
// MMIO responder covering reset, LED gating, cycle counter and the TX FIFO.
module tb_mmio_responder;

    logic        clock;
    logic        resetN;
    logic [11:0] address;
    logic [31:0] storeData;
    logic        writeEn;
    logic        memWren;
    logic [31:0] qMmio;
    logic        mmioHit;
    logic [7:0]  ledOut;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;

    int assertCount = 0;
    int failCount   = 0;

    mmio_responder dut (
        .clock        (clock),
        .reset        (resetN),
        .address_dmem (address),
        .data         (storeData),
        .wren         (writeEn),
        .mem_wren     (memWren),
        .q_mmio       (qMmio),
        .mmio_hit     (mmioHit),
        .led          (ledOut),
        .tx_data      (txData),
        .tx_valid     (txValid),
        .tx_ready     (txReady)
    );

    // 100 MHz clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic applyStimulus(input logic [11:0] a, input logic [31:0] d,
                                 input logic w, input logic r);
        address   = a;
        storeData = d;
        writeEn   = w;
        txReady   = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Main directed sequence.
    initial begin
        resetN = 1'b0;
        applyStimulus(12'h010, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst_led",      {24'b0, ledOut}, 32'h0);
        checkOutput("rst_q",        qMmio,           32'h0);
        checkOutput("rst_hit",      {31'b0, mmioHit}, 32'h0);
        checkOutput("rst_txvalid",  {31'b0, txValid}, 32'h0);
        checkOutput("rst_txdata",   {24'b0, txData}, 32'h0);
        resetN = 1'b1;
        tick();

        // LED write with dmem gating.
        applyStimulus(12'hFF0, 32'h1234_56A5, 1'b1, 1'b0);
        #1 checkOutput("led_memwren_gated", {31'b0, memWren}, 32'h0);
        tick();
        checkOutput("led_written", {24'b0, ledOut}, 32'hA5);
        applyStimulus(12'h010, 32'h0000_0033, 1'b1, 1'b0);
        #1 checkOutput("dmem_memwren", {31'b0, memWren}, 32'h1);
        tick();
        checkOutput("led_unchanged", {24'b0, ledOut}, 32'hA5);
        applyStimulus(12'hFF0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("led_read_q",   qMmio,            32'h0000_00A5);
        checkOutput("led_read_hit", {31'b0, mmioHit}, 32'h1);
        applyStimulus(12'h010, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("miss_q",   qMmio,            32'h0);
        checkOutput("miss_hit", {31'b0, mmioHit}, 32'h0);

        // Cycle counter: clear, idle nine edges, read on the tenth.
        applyStimulus(12'hFF1, 32'h0, 1'b1, 1'b0);
        tick();
        applyStimulus(12'h010, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        applyStimulus(12'hFF1, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("cycle_read", qMmio, 32'd9);

        // FIFO fill past capacity with the sink stalled.
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(12'hFF2, 32'(i), 1'b1, 1'b0);
            tick();
        end
        checkOutput("fill_txvalid", {31'b0, txValid}, 32'h1);
        checkOutput("fill_txdata",  {24'b0, txData},  32'h01);
        applyStimulus(12'hFF3, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("fill_status", qMmio, 32'h0000_0281);

        // Drain: 0x01..0x08 in order, dropped 0x09 never appears.
        applyStimulus(12'h010, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("drain_valid_%0d", i), {31'b0, txValid}, 32'h1);
            checkOutput($sformatf("drain_data_%0d", i),  {24'b0, txData},  32'(i + 1));
            tick();
        end
        checkOutput("drain_empty", {31'b0, txValid}, 32'h0);
        applyStimulus(12'hFF3, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("status_ovf_sticky", qMmio, 32'h0000_0202);
        applyStimulus(12'hFF3, 32'h0000_0200, 1'b1, 1'b0);
        tick();
        applyStimulus(12'hFF3, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("status_ovf_cleared", qMmio, 32'h0000_0002);

        // Fill with 0x11..0x18, then push 0x10 while full and popping.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(12'hFF2, 32'h11 + 32'(i), 1'b1, 1'b0);
            tick();
        end
        applyStimulus(12'hFF2, 32'h10, 1'b1, 1'b1);
        tick();
        applyStimulus(12'hFF3, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("pushpop_status", qMmio, 32'h0000_0081);
        applyStimulus(12'h010, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("wrap_valid_%0d", i), {31'b0, txValid}, 32'h1);
            checkOutput($sformatf("wrap_data_%0d", i), {24'b0, txData},
                        (i < 7) ? 32'h12 + 32'(i) : 32'h10);
            tick();
        end
        checkOutput("wrap_empty", {31'b0, txValid}, 32'h0);

        // Push into empty FIFO: no bypass, visible one cycle later.
        applyStimulus(12'hFF2, 32'h77, 1'b1, 1'b0);
        #1 checkOutput("empty_push_same", {31'b0, txValid}, 32'h0);
        tick();
        checkOutput("empty_push_valid", {31'b0, txValid}, 32'h1);
        checkOutput("empty_push_data",  {24'b0, txData},  32'h77);

        // Mid-operation reset with 3 bytes queued and led = 0x5A.
        applyStimulus(12'hFF0, 32'h5A, 1'b1, 1'b0);
        tick();
        applyStimulus(12'hFF2, 32'h31, 1'b1, 1'b0);
        tick();
        applyStimulus(12'hFF2, 32'h32, 1'b1, 1'b0);
        tick();
        applyStimulus(12'hFF3, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("pre_rst_status", qMmio, 32'h0000_0030);
        checkOutput("pre_rst_hit", {31'b0, mmioHit}, 32'h1);
        checkOutput("pre_rst_led", {24'b0, ledOut},  32'h5A);
        #2 resetN = 1'b0;
        #1;
        checkOutput("async_rst_txvalid", {31'b0, txValid}, 32'h0);
        checkOutput("async_rst_led",     {24'b0, ledOut},  32'h0);
        checkOutput("async_rst_hit",     {31'b0, mmioHit}, 32'h0);
        tick();
        resetN = 1'b1;
        applyStimulus(12'hFF3, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("post_rst_status", qMmio, 32'h0000_0002);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
